// File: rtl/axil_plic_pkg.sv
// Shared types and constants for the AXI4-Lite to PLIC BRAM-port bridge.
package axil_plic_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 22;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WR_EN,
    WR_RESP,
    RD_EN,
    RD_CAP,
    RD_RESP
  } state_t;

endpackage

// File: rtl/axil_plic_bridge.sv
// AXI4-Lite slave that serialises reads and writes onto the PLIC BRAM control port.
// One transaction in flight; alternating priority when both channels are pending.
module axil_plic_bridge
  import axil_plic_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic [DATA_WIDTH-1:0]   bram_wrdata,
  input  logic [DATA_WIDTH-1:0]   bram_rddata
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  state_t state;
  logic   wr_first;
  logic   wr_pend;
  logic   grant_wr;
  logic   grant_rd;
  logic   idle_c;

  // Arbitration: the flag points at the channel that wins a tie.
  assign wr_pend  = s_awvalid && s_wvalid;
  assign grant_wr = wr_pend && (wr_first || !s_arvalid);
  assign grant_rd = s_arvalid && (!wr_pend || !wr_first);
  assign idle_c   = rstn && (state == IDLE);

  assign s_awready = idle_c && grant_wr;
  assign s_wready  = idle_c && grant_wr;
  assign s_arready = idle_c && grant_rd;
  assign s_bresp   = RESP_OKAY;
  assign s_rresp   = RESP_OKAY;

  // The BRAM output registers double as the request latches.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      wr_first    <= 1'b1;
      s_bvalid    <= 1'b0;
      s_rvalid    <= 1'b0;
      s_rdata     <= '0;
      bram_en     <= 1'b0;
      bram_we     <= '0;
      bram_addr   <= '0;
      bram_wrdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            bram_en     <= 1'b1;
            bram_we     <= s_wstrb;
            bram_addr   <= s_awaddr & WORD_MASK;
            bram_wrdata <= s_wdata;
            wr_first    <= 1'b0;
            state       <= WR_EN;
          end else if (grant_rd) begin
            bram_en   <= 1'b1;
            bram_we   <= '0;
            bram_addr <= s_araddr & WORD_MASK;
            wr_first  <= 1'b1;
            state     <= RD_EN;
          end
        end
        WR_EN: begin
          bram_en  <= 1'b0;
          bram_we  <= '0;
          s_bvalid <= 1'b1;
          state    <= WR_RESP;
        end
        WR_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_EN: begin
          bram_en <= 1'b0;
          state   <= RD_CAP;
        end
        RD_CAP: begin
          s_rdata  <= bram_rddata;
          s_rvalid <= 1'b1;
          state    <= RD_RESP;
        end
        RD_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_plic_bridge.sv
// Directed self-checking bench for axil_plic_bridge with a small BRAM model.
module tb_axil_plic_bridge;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] s_awaddr = '0;
  logic          s_awvalid = 1'b0;
  logic          s_awready;
  logic [31:0]   s_wdata = '0;
  logic [3:0]    s_wstrb = '0;
  logic          s_wvalid = 1'b0;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready = 1'b0;
  logic [AW-1:0] s_araddr = '0;
  logic          s_arvalid = 1'b0;
  logic          s_arready;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready = 1'b0;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [31:0]   bram_wrdata;
  logic [31:0]   rddata = '0;

  axil_plic_bridge dut (
    .clk(clk), .rstn(rstn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_wrdata(bram_wrdata), .bram_rddata(rddata)
  );

  always #5 clk = ~clk;

  // BRAM model: 32 words indexed by {addr[21], addr[5:2]}, read latency 1.
  logic [31:0] mem [32];
  logic        order [$];
  int          en_count = 0;
  int          viol = 0;
  logic        prev_en = 1'b0;

  function automatic int midx(input logic [AW-1:0] a);
    return int'({a[21], a[5:2]});
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    prev_en <= bram_en;
    if (bram_en) begin
      en_count <= en_count + 1;
      if (bram_we != 4'h0) begin
        mem[midx(bram_addr)] <= merge(mem[midx(bram_addr)], bram_wrdata, bram_we);
        order.push_back(1'b1);
      end else begin
        rddata <= mem[midx(bram_addr)];
        order.push_back(1'b0);
      end
    end
    if ((bram_en && prev_en) || (!bram_en && bram_we != 4'h0)) viol <= viol + 1;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(bram_en), 0);
    chk({tag, "_we"}, 32'(bram_we), 0);
    chk({tag, "_addr"}, 32'(bram_addr), 0);
    chk({tag, "_wrdata"}, bram_wrdata, 0);
    chk({tag, "_bvalid"}, 32'(s_bvalid), 0);
    chk({tag, "_rvalid"}, 32'(s_rvalid), 0);
    chk({tag, "_rdata"}, s_rdata, 0);
    chk({tag, "_rdy"}, {29'd0, s_awready, s_wready, s_arready}, 0);
  endtask

  initial begin
    int start;
    int en0;
    int waited;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[17] = 32'h0000_0007;

    // Reset state
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    tick(); tick();
    chk_all_zero("reset");
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    rstn = 1'b1;
    tick();

    // Single write
    s_awaddr = 22'h000004; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    #1;
    chk("wr_awready", 32'(s_awready), 1);
    chk("wr_wready", 32'(s_wready), 1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("wr_en", 32'(bram_en), 1);
    chk("wr_we", 32'(bram_we), 32'hF);
    chk("wr_addr", 32'(bram_addr), 32'h4);
    chk("wr_data", bram_wrdata, 32'hDEADBEEF);
    chk("wr_bvalid_t1", 32'(s_bvalid), 0);
    tick();
    chk("wr_bvalid_t2", 32'(s_bvalid), 1);
    chk("wr_bresp", 32'(s_bresp), 0);
    chk("wr_en_off", 32'(bram_en), 0);
    tick();
    chk("wr_bvalid_done", 32'(s_bvalid), 0);
    chk("wr_mem", mem[1], 32'hDEADBEEF);

    // Single read
    en0 = en_count;
    s_araddr = 22'h200004; s_arvalid = 1'b1; s_rready = 1'b1;
    #1;
    chk("rd_arready", 32'(s_arready), 1);
    tick();
    s_arvalid = 1'b0;
    chk("rd_en", 32'(bram_en), 1);
    chk("rd_we", 32'(bram_we), 0);
    chk("rd_addr", 32'(bram_addr), 32'h200004);
    tick();
    chk("rd_rvalid_t2", 32'(s_rvalid), 0);
    chk("rd_en_off", 32'(bram_en), 0);
    tick();
    chk("rd_rvalid_t3", 32'(s_rvalid), 1);
    chk("rd_rdata", s_rdata, 32'h7);
    chk("rd_rresp", 32'(s_rresp), 0);
    tick();
    chk("rd_rvalid_done", 32'(s_rvalid), 0);
    chk("rd_en_pulses", 32'(en_count - en0), 1);

    // Strobe and alignment
    s_awaddr = 22'h000007; s_wdata = 32'h11112222; s_wstrb = 4'h3;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("strb_addr", 32'(bram_addr), 32'h4);
    chk("strb_we", 32'(bram_we), 32'h3);
    tick();
    chk("strb_bvalid", 32'(s_bvalid), 1);
    chk("strb_bresp", 32'(s_bresp), 0);
    tick();

    // Write backpressure with a read waiting
    s_awaddr = 22'h000010; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 22'h200004; s_arvalid = 1'b1; s_rready = 1'b0;
    #1;
    chk("bp_arready_wren", 32'(s_arready), 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid_hold", 32'(s_bvalid), 1);
      chk("bp_arready_hold", 32'(s_arready), 0);
      tick();
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("bp_bvalid_done", 32'(s_bvalid), 0);
    chk("bp_arready_idle", 32'(s_arready), 1);
    tick();
    s_arvalid = 1'b0;
    s_awaddr = 22'h000020; s_wdata = 32'h5A5A5A5A;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    chk("bp_awready_rden", 32'(s_awready), 0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid_hold", 32'(s_rvalid), 1);
      chk("bp_rdata_hold", s_rdata, 32'h7);
      chk("bp_awready_hold", 32'(s_awready), 0);
      tick();
    end
    s_rready = 1'b1;
    tick();
    chk("bp_rvalid_done", 32'(s_rvalid), 0);
    chk("bp_awready_idle", 32'(s_awready), 1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    chk("bp_wr2_addr", 32'(bram_addr), 32'h20);
    tick(); tick(); tick();
    chk("bp_mem10", mem[4], 32'hA5A5A5A5);

    // Contention from reset: order W, R, W, R
    rstn = 1'b0;
    s_awaddr = 22'h000030; s_wdata = 32'h0C0C0C0C; s_wstrb = 4'hF;
    s_araddr = 22'h200004;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    s_bready = 1'b1; s_rready = 1'b1;
    tick();
    start = order.size();
    rstn = 1'b1;
    waited = 0;
    while (order.size() < start + 4 && waited < 40) begin
      tick();
      waited++;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    chk("cont_done", 32'(order.size() >= start + 4), 1);
    repeat (6) tick();
    chk("cont_count", 32'(order.size() - start), 4);
    if (order.size() >= start + 4) begin
      chk("cont_order", {28'd0, order[start], order[start+1], order[start+2], order[start+3]},
          32'b1010);
    end
    chk("bram_protocol", 32'(viol), 0);

    // Reset during RD_CAP drops the read
    s_araddr = 22'h200004; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    tick();
    rstn = 1'b0;
    en0 = en_count;
    tick();
    rstn = 1'b1;
    chk_all_zero("midrst");
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_rvalid", 32'(s_rvalid), 0);
      tick();
    end
    chk("midrst_no_en", 32'(en_count - en0), 0);
    s_araddr = 22'h000004; s_arvalid = 1'b1;
    #1;
    chk("fresh_arready", 32'(s_arready), 1);
    tick();
    s_arvalid = 1'b0;
    waited = 0;
    while (!s_rvalid && waited < 10) begin
      tick();
      waited++;
    end
    chk("fresh_rvalid", 32'(s_rvalid), 1);
    chk("fresh_latency", 32'(waited), 2);
    chk("fresh_rdata", s_rdata, 32'hDEAD2222);
    tick();
    chk("final_protocol", 32'(viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axil_plic_bridge.md
Name: axil_plic_bridge

Overview:
- AXI4-Lite slave to BRAM-master bridge that drives the BRAM-style control port of the PLIC wrapper (22-bit byte address, 32-bit data, read latency 1).
- Sits between the SoC AXI-Lite peripheral interconnect and the PLIC.
- Serialises reads and writes: one outstanding transaction, fair arbitration between the two channels.

Parameters:
- ADDR_WIDTH, 22, byte-address width of the AXI and BRAM sides (4 MiB window).
- DATA_WIDTH, 32, data width; fixed at 32 (WSTRB/WE width = 4).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s_awaddr  in  ADDR_WIDTH  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  32  write data
- s_wstrb  in  4  write byte strobes
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response, always OKAY (2'b00)
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  ADDR_WIDTH  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  32  read data
- s_rresp  out  2  read response, always OKAY
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- bram_addr  out  ADDR_WIDTH  BRAM byte address; bits [1:0] always 0
- bram_en  out  1  BRAM enable
- bram_we  out  4  BRAM byte write enables
- bram_wrdata  out  32  BRAM write data
- bram_rddata  in  32  BRAM read data, valid one cycle after the bram_en read cycle

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-low; it acts on the clk edge only. While rstn=0:
  - FSM goes to IDLE and the priority flag goes to "write-first".
  - All outputs are 0: s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_rdata, bram_en, bram_we, bram_addr, bram_wrdata.
- Reset mid-transaction drops the in-flight request and response with no BRAM side effect after reset. A write whose WR_EN cycle already executed stays in memory.
- FSM states:
  - IDLE
  - WR_EN: one cycle. bram_en=1, bram_we=latched wstrb, bram_wrdata=latched wdata, bram_addr=latched addr.
  - WR_RESP: s_bvalid=1, held until s_bready.
  - RD_EN: one cycle. bram_en=1, bram_we=0, bram_addr=latched addr.
  - RD_CAP: s_rdata <= bram_rddata.
  - RD_RESP: s_rvalid=1 with s_rdata stable, held until s_rready.
- Write acceptance (IDLE only): a write is pending when s_awvalid && s_wvalid. AW and W are only ever accepted together.
  - s_awready = s_wready = 1 in the same cycle, combinationally, iff IDLE && write pending && write granted.
  - Latches {awaddr[21:2],2'b00}, wdata and wstrb; next state WR_EN.
- Read acceptance (IDLE only): s_arready = 1 iff IDLE && s_arvalid && read granted. Latches {araddr[21:2],2'b00}; next state RD_EN.
- Arbitration when both are pending in IDLE: grant the channel opposite to the last one served. The flag resets to write-first. With only one pending, grant it.
- Latencies:
  - Write: handshake at edge T, bram_en/we in cycle T+1, s_bvalid from T+2.
  - Read: handshake at T, bram_en in T+1, capture in T+2, s_rvalid from T+3.
- Response completion:
  - WR_RESP→IDLE and RD_RESP→IDLE on the handshake edge.
  - No new request is accepted in the same cycle as the response handshake. Minimum spacing is 3 cycles per write and 4 per read.
- Partial strobes pass through unchanged. The PLIC ignores non-full-word writes; the bridge does not filter them. wstrb=0 still produces a bram_en cycle with we=0.
- bram_en is never asserted outside WR_EN/RD_EN. bram_we is nonzero only in WR_EN.
- Unaligned addresses: bits [1:0] are dropped silently and the response is still OKAY.

Decomposition:
- Shared package axil_plic_pkg holds:
  - state enum {IDLE, WR_EN, WR_RESP, RD_EN, RD_CAP, RD_RESP}
  - RESP_OKAY = 2'b00
  - ADDR_WIDTH default
- No sub-module: the FSM, latches and arbiter flag all live in the single module.

Test Plan:
- Single write: awaddr=0x000004, wdata=0xDEADBEEF, wstrb=0xF, bready=1 → one cycle with bram_en=1, we=0xF, addr=0x000004, wrdata=0xDEADBEEF; bvalid at T+2 with bresp=0.
- Single read: araddr=0x200004, model returns 0x00000007 one cycle after en → rvalid at T+3 with rdata=0x00000007 and rresp=0; exactly one bram_en pulse with we=0.
- Contention: AW/W and AR all valid continuously from reset for 4 transactions → order is W, R, W, R; bram_en pulses never overlap.
- Backpressure: hold bready=0 for 5 cycles, then rready=0 for 5 cycles.
  - bvalid and rvalid stay high with stable rdata.
  - arready/awready stay 0 until each handshake completes.
- Strobe/alignment: awaddr=0x000007, wstrb=0x3 → bram_addr=0x000004, bram_we=0x3, bresp OKAY.
- Reset mid-read: drop rstn for 1 cycle in RD_CAP → all outputs 0 the next cycle; rvalid never asserts for the dropped read; a fresh read afterwards completes normally.
